// File: rtl/pla_sop_eval_seq.sv
// -----------------------------------------------------------------------------
// pla_sop_eval_seq
//
// Sequential evaluator for multi-output two-level (PLA / sum-of-products)
// logic functions. A run-time loadable cube table holds NUM_CUBES entries.
// Each entry has a care mask, a literal polarity vector and an output mask.
// An accepted input vector is compared against LANES cubes per clock. Each
// output bit is the OR of the output masks of all matching cubes, XORed with
// a per-output inversion register when the result is presented.
//
// Intended as a golden, reloadable reference that runs beside synthesised
// benchmark netlists during equivalence runs.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   cfg_we           write cube entry cfg_addr (care/val/omask)
//   cfg_addr         cube index; indices >= NUM_CUBES are ignored
//   cfg_care         1 = literal present in the cube
//   cfg_val          literal polarity (1 = positive)
//   cfg_omask        outputs this cube feeds; all-zero disables the entry
//   cfg_pol_we       write the output inversion register
//   cfg_pol          1 = invert that output
//   cfg_clear        disable every entry (wins over cfg_we)
//   cfg_ready        config is taken this cycle (high only while idle)
//   in_valid/in_ready/in_x     input vector handshake
//   out_valid/out_ready/out_y  result handshake; out_y holds under stall
//   busy             a vector is being scanned or is waiting for its consumer
// -----------------------------------------------------------------------------
module pla_sop_eval_seq #(
  parameter int NUM_IN    = 8,
  parameter int NUM_OUT   = 1,
  parameter int NUM_CUBES = 16,
  parameter int LANES     = 4,
  localparam int AW       = (NUM_CUBES > 1) ? $clog2(NUM_CUBES) : 1,
  localparam int BEATS    = (NUM_CUBES + LANES - 1) / LANES
) (
  input  logic               clk,
  input  logic               rst_n,
  // configuration
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [NUM_IN-1:0]  cfg_care,
  input  logic [NUM_IN-1:0]  cfg_val,
  input  logic [NUM_OUT-1:0] cfg_omask,
  input  logic               cfg_pol_we,
  input  logic [NUM_OUT-1:0] cfg_pol,
  input  logic               cfg_clear,
  output logic               cfg_ready,
  // input vector stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_x,
  // result stream
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_y,
  output logic               busy
);

  // Beat counter is one bit wider than needed to index BEATS-1 so that the
  // BEATS == 1 case still has a non-zero-width counter.
  localparam int KW = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic               idle_q;     // registered copy of (state == IDLE)
  logic [NUM_IN-1:0]  x_q;        // vector latched at the input handshake
  logic [NUM_OUT-1:0] acc;        // OR of omasks of cubes matched so far
  logic [KW-1:0]      beat_cnt;   // current scan beat, 0 .. BEATS-1

  // Cube table and output polarity.
  logic [NUM_IN-1:0]  care_mem  [NUM_CUBES];
  logic [NUM_IN-1:0]  val_mem   [NUM_CUBES];
  logic [NUM_OUT-1:0] omask_mem [NUM_CUBES];
  logic [NUM_OUT-1:0] pol_q;

  logic               cfg_addr_ok;
  logic [NUM_OUT-1:0] beat_hits;  // OR of omasks matched in the current beat

  // ---------------------------------------------------------------------------
  // Cube match: every literal that is present agrees with the input bit.
  // ---------------------------------------------------------------------------
  function automatic logic cube_match(input logic [NUM_IN-1:0] care,
                                      input logic [NUM_IN-1:0] val,
                                      input logic [NUM_IN-1:0] x);
    return ((x ^ val) & care) == '0;
  endfunction

  assign cfg_addr_ok = int'(cfg_addr) < NUM_CUBES;

  // ---------------------------------------------------------------------------
  // Cube table. Config is only honoured while idle, so the table and the
  // polarity register never change under a vector in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table must come up empty after reset (and a reset mid-scan
      // must leave it empty), so it is built from resettable flops rather
      // than an unreset RAM.
      for (int i = 0; i < NUM_CUBES; i++) begin
        care_mem[i]  <= '0;
        val_mem[i]   <= '0;
        omask_mem[i] <= '0;
      end
      pol_q <= '0;
    end else if (idle_q) begin
      if (cfg_clear) begin
        for (int i = 0; i < NUM_CUBES; i++) begin
          care_mem[i]  <= '0;
          val_mem[i]   <= '0;
          omask_mem[i] <= '0;
        end
      end else if (cfg_we && cfg_addr_ok) begin
        care_mem[cfg_addr]  <= cfg_care;
        val_mem[cfg_addr]   <= cfg_val;
        omask_mem[cfg_addr] <= cfg_omask;
      end
      if (cfg_pol_we) begin
        pol_q <= cfg_pol;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One scan beat: LANES cubes starting at beat_cnt*LANES. Lanes that fall
  // past the end of the table in the last beat are skipped. A disabled entry
  // has omask == 0 and therefore ORs in nothing.
  // ---------------------------------------------------------------------------
  always_comb begin : scan_lanes
    int idx;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    idx       = 0;
    beat_hits = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat_cnt) * LANES + l;
      if (idx < NUM_CUBES) begin
        if (cube_match(care_mem[AW'(idx)], val_mem[AW'(idx)], x_q)) begin
          beat_hits = beat_hits | omask_mem[AW'(idx)];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> SCAN (BEATS cycles) -> DONE -> IDLE.
  // All handshake outputs are registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state     <= IDLE;
      idle_q    <= 1'b1;
      x_q       <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= in_x;
            acc      <= '0;
            beat_cnt <= '0;
            idle_q   <= 1'b0;
            state    <= SCAN;
          end
        end

        SCAN: begin
          acc <= acc | beat_hits;
          if (beat_cnt == KW'(BEATS - 1)) begin
            // Polarity is applied here; it cannot have moved since the
            // handshake because config is blocked outside IDLE.
            out_y     <= (acc | beat_hits) ^ pol_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        DONE: begin
          // out_y is untouched here, so it holds while the consumer stalls.
          if (out_ready) begin
            out_valid <= 1'b0;
            idle_q    <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          idle_q    <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = idle_q;
  assign cfg_ready = idle_q;
  assign busy      = ~idle_q;

endmodule

// File: tb/tb_pla_sop_eval_seq.sv
// -----------------------------------------------------------------------------
// tb_pla_sop_eval_seq
//
// Two instances: dut_a with the default geometry (8 in, 1 out, 16 cubes,
// 4 lanes -> 4 beats) and dut_b with 8 in, 3 out, 10 cubes, 4 lanes
// (3 beats, partial last beat). Expected results come from a plain
// cube-list model of the PLA kept in the bench.
// -----------------------------------------------------------------------------
module tb_pla_sop_eval_seq;

  localparam int B_A = 4;
  localparam int B_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A signals ----------------
  logic       a_rst_n;
  logic       a_cfg_we, a_cfg_pol_we, a_cfg_clear, a_cfg_ready;
  logic [3:0] a_cfg_addr;
  logic [7:0] a_cfg_care, a_cfg_val;
  logic [0:0] a_cfg_omask, a_cfg_pol;
  logic       a_in_valid, a_in_ready;
  logic [7:0] a_in_x;
  logic       a_out_valid, a_out_ready, a_busy;
  logic [0:0] a_out_y;

  // ---------------- instance B signals ----------------
  logic       b_rst_n;
  logic       b_cfg_we, b_cfg_pol_we, b_cfg_clear, b_cfg_ready;
  logic [3:0] b_cfg_addr;
  logic [7:0] b_cfg_care, b_cfg_val;
  logic [2:0] b_cfg_omask, b_cfg_pol;
  logic       b_in_valid, b_in_ready;
  logic [7:0] b_in_x;
  logic       b_out_valid, b_out_ready, b_busy;
  logic [2:0] b_out_y;

  pla_sop_eval_seq #(.NUM_IN(8), .NUM_OUT(1), .NUM_CUBES(16), .LANES(4)) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .cfg_we(a_cfg_we), .cfg_addr(a_cfg_addr), .cfg_care(a_cfg_care),
    .cfg_val(a_cfg_val), .cfg_omask(a_cfg_omask), .cfg_pol_we(a_cfg_pol_we),
    .cfg_pol(a_cfg_pol), .cfg_clear(a_cfg_clear), .cfg_ready(a_cfg_ready),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y),
    .busy(a_busy)
  );

  pla_sop_eval_seq #(.NUM_IN(8), .NUM_OUT(3), .NUM_CUBES(10), .LANES(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_care(b_cfg_care),
    .cfg_val(b_cfg_val), .cfg_omask(b_cfg_omask), .cfg_pol_we(b_cfg_pol_we),
    .cfg_pol(b_cfg_pol), .cfg_clear(b_cfg_clear), .cfg_ready(b_cfg_ready),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y),
    .busy(b_busy)
  );

  // ---------------- reference model: a list of cubes ----------------
  bit [7:0] ma_care [16];
  bit [7:0] ma_val  [16];
  bit       ma_om   [16];
  bit       ma_pol;

  bit [7:0] mb_care [10];
  bit [7:0] mb_val  [10];
  bit [2:0] mb_om   [10];
  bit [2:0] mb_pol;

  function automatic bit model_a(input logic [7:0] x);
    bit acc = 1'b0;
    for (int i = 0; i < 16; i++)
      if (((x ^ ma_val[i]) & ma_care[i]) == 8'h00) acc = acc | ma_om[i];
    return acc ^ ma_pol;
  endfunction

  function automatic bit [2:0] model_b(input logic [7:0] x);
    bit [2:0] acc = 3'b000;
    for (int i = 0; i < 10; i++)
      if (((x ^ mb_val[i]) & mb_care[i]) == 8'h00) acc = acc | mb_om[i];
    return acc ^ mb_pol;
  endfunction

  task automatic model_a_reset();
    for (int i = 0; i < 16; i++) begin
      ma_care[i] = '0; ma_val[i] = '0; ma_om[i] = 1'b0;
    end
    ma_pol = 1'b0;
  endtask

  task automatic model_b_reset();
    for (int i = 0; i < 10; i++) begin
      mb_care[i] = '0; mb_val[i] = '0; mb_om[i] = '0;
    end
    mb_pol = '0;
  endtask

  // ---------------- drivers (start and end on a falling edge) ----------------
  task automatic a_write(input int addr, input logic [7:0] care,
                         input logic [7:0] val, input bit om);
    a_cfg_we = 1'b1; a_cfg_addr = addr[3:0]; a_cfg_care = care;
    a_cfg_val = val; a_cfg_omask = om;
    @(negedge clk);
    a_cfg_we = 1'b0;
    ma_care[addr] = care; ma_val[addr] = val; ma_om[addr] = om;
  endtask

  task automatic a_set_pol(input bit p);
    a_cfg_pol_we = 1'b1; a_cfg_pol = p;
    @(negedge clk);
    a_cfg_pol_we = 1'b0;
    ma_pol = p;
  endtask

  task automatic a_clear();
    a_cfg_clear = 1'b1;
    @(negedge clk);
    a_cfg_clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ma_care[i] = '0; ma_val[i] = '0; ma_om[i] = 1'b0;
    end
  endtask

  // Waits for out_valid; lat = falling edges since the handshake edge,
  // -1 when the bound expires.
  task automatic a_wait_result(output bit y, output int lat);
    lat = -1; y = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (a_out_valid) begin
        lat = n; y = a_out_y; break;
      end
      @(negedge clk);
    end
  endtask

  task automatic a_run(input logic [7:0] x, output bit y, output int lat);
    a_in_valid = 1'b1; a_in_x = x;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_wait_result(y, lat);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic b_write(input int addr, input logic [7:0] care,
                         input logic [7:0] val, input logic [2:0] om);
    b_cfg_we = 1'b1; b_cfg_addr = addr[3:0]; b_cfg_care = care;
    b_cfg_val = val; b_cfg_omask = om;
    @(negedge clk);
    b_cfg_we = 1'b0;
    if (addr < 10) begin
      mb_care[addr] = care; mb_val[addr] = val; mb_om[addr] = om;
    end
  endtask

  task automatic b_run(input logic [7:0] x, output logic [2:0] y, output int lat);
    b_in_valid = 1'b1; b_in_x = x;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = -1; y = '0;
    for (int n = 0; n <= 20; n++) begin
      if (b_out_valid) begin
        lat = n; y = b_out_y; break;
      end
      @(negedge clk);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++;
    if ({a_out_valid, a_out_y, a_busy, a_in_ready, a_cfg_ready} !== 5'b00011) begin
      n_bad++;
      $display("FAIL reset_a: {valid,y,busy,in_rdy,cfg_rdy} got %b want 00011",
               {a_out_valid, a_out_y, a_busy, a_in_ready, a_cfg_ready});
    end
    n_cmp++;
    if ({b_out_valid, b_out_y, b_busy, b_in_ready, b_cfg_ready} !== 7'b0000011) begin
      n_bad++;
      $display("FAIL reset_b: {valid,y,busy,in_rdy,cfg_rdy} got %b want 0000011",
               {b_out_valid, b_out_y, b_busy, b_in_ready, b_cfg_ready});
    end
  endtask

  task automatic test_basic();
    logic [7:0] xs [3] = '{8'h01, 8'h05, 8'hF9};
    bit y; int lat;
    a_write(0, 8'h07, 8'h01, 1'b1);
    a_set_pol(1'b1);
    foreach (xs[i]) begin
      a_run(xs[i], y, lat);
      n_cmp++;
      if (lat != B_A) begin
        n_bad++; $display("FAIL basic_latency x=%h: got %0d want %0d", xs[i], lat, B_A);
      end
      n_cmp++;
      if (y !== model_a(xs[i])) begin
        n_bad++; $display("FAIL basic_y x=%h: got %b want %b", xs[i], y, model_a(xs[i]));
      end
    end
  endtask

  task automatic test_last_beat();
    bit y; int lat; logic [7:0] x;
    a_set_pol(1'b0);
    a_write(3, 8'h00, 8'h00, 1'b0);
    a_write(15, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      x = 8'($urandom);
      a_run(x, y, lat);
      n_cmp++;
      if (y !== model_a(x) || lat != B_A) begin
        n_bad++;
        $display("FAIL last_beat x=%h: got y=%b lat=%0d want y=%b lat=%0d",
                 x, y, lat, model_a(x), B_A);
      end
    end
  endtask

  task automatic test_backpressure();
    bit y, y0; int lat;
    a_clear();
    a_write(0, 8'hFF, 8'h3C, 1'b1);
    a_in_valid = 1'b1; a_in_x = 8'h3C;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_wait_result(y0, lat);
    n_cmp++;
    if (lat != B_A || y0 !== model_a(8'h3C)) begin
      n_bad++;
      $display("FAIL bp_first: got y=%b lat=%0d want y=%b lat=%0d",
               y0, lat, model_a(8'h3C), B_A);
    end
    for (int c = 0; c < 5; c++) begin
      // Dropped write: the model is deliberately not updated.
      a_cfg_we = (c == 2); a_cfg_addr = 4'd1; a_cfg_care = 8'hFF;
      a_cfg_val = 8'h55; a_cfg_omask = 1'b1;
      @(negedge clk);
      a_cfg_we = 1'b0;
      n_cmp++;
      if ({a_out_valid, a_out_y, a_in_ready, a_cfg_ready, a_busy} !== {1'b1, y0, 3'b001}) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: {valid,y,in_rdy,cfg_rdy,busy} got %b want %b",
                 c, {a_out_valid, a_out_y, a_in_ready, a_cfg_ready, a_busy},
                 {1'b1, y0, 3'b001});
      end
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_run(8'h55, y, lat);
    n_cmp++;
    if (y !== model_a(8'h55)) begin
      n_bad++; $display("FAIL bp_dropped_write: got %b want %b", y, model_a(8'h55));
    end
  endtask

  task automatic test_same_cycle();
    bit y; int lat;
    a_set_pol(1'b1);
    a_cfg_we = 1'b1; a_cfg_addr = 4'd2; a_cfg_care = 8'hFF; a_cfg_val = 8'hAA;
    a_cfg_omask = 1'b1; a_cfg_pol_we = 1'b1; a_cfg_pol = 1'b0;
    a_in_valid = 1'b1; a_in_x = 8'hAA;
    ma_care[2] = 8'hFF; ma_val[2] = 8'hAA; ma_om[2] = 1'b1; ma_pol = 1'b0;
    @(negedge clk);
    a_cfg_we = 1'b0; a_cfg_pol_we = 1'b0; a_in_valid = 1'b0;
    a_wait_result(y, lat);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_cmp++;
    if (y !== model_a(8'hAA) || lat != B_A) begin
      n_bad++;
      $display("FAIL same_cycle: got y=%b lat=%0d want y=%b lat=%0d",
               y, lat, model_a(8'hAA), B_A);
    end
  endtask

  task automatic test_random();
    bit y; int lat; logic [7:0] x; int e;
    for (int r = 0; r < 4; r++) begin
      if (r == 2) a_clear();
      for (int w = 0; w < 6; w++) begin
        e = $urandom_range(0, 15);
        a_write(e, 8'($urandom & $urandom & $urandom), 8'($urandom),
                1'($urandom_range(0, 3) != 0));
      end
      a_set_pol(1'($urandom));
      for (int v = 0; v < 8; v++) begin
        e = $urandom_range(0, 15);
        x = (v % 2 == 0) ? (ma_val[e] ^ 8'($urandom & $urandom & $urandom)) : 8'($urandom);
        a_run(x, y, lat);
        n_cmp++;
        if (y !== model_a(x) || lat != B_A) begin
          n_bad++;
          $display("FAIL random r%0d v%0d x=%h: got y=%b lat=%0d want y=%b lat=%0d",
                   r, v, x, y, lat, model_a(x), B_A);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_q [$];
    int sent = 0, got = 0;
    logic [7:0] x;
    bit e;
    a_out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (a_out_valid) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : ~a_out_y;
        n_cmp++;
        if (a_out_y !== e) begin
          n_bad++; $display("FAIL back_to_back #%0d: got %b want %b", got, a_out_y, e);
        end
        got++;
      end
      if (sent < 6 && a_in_ready) begin
        x = 8'($urandom);
        a_in_valid = 1'b1; a_in_x = x;
        exp_q.push_back(model_a(x));
        sent++;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    n_cmp++;
    if (got != 6) begin
      n_bad++; $display("FAIL back_to_back_count: got %0d results want 6", got);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit y, seen; int lat; logic [7:0] x;
    a_write(4, 8'h00, 8'h00, 1'b1);
    a_in_valid = 1'b1; a_in_x = 8'h5A;
    @(negedge clk);             // handshake edge passed
    a_in_valid = 1'b0;
    @(negedge clk);             // beat 0 done
    @(negedge clk);             // beat 1 done, beat 2 in progress
    n_cmp++;
    if (a_busy !== 1'b1) begin
      n_bad++; $display("FAIL midscan_busy: got %b want 1", a_busy);
    end
    a_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL midscan_async: {valid,busy,in_rdy} got %b want 001",
               {a_out_valid, a_busy, a_in_ready});
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    model_a_reset();
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (a_out_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL midscan_no_result: out_valid seen=%b want 0", seen);
    end
    x = 8'($urandom);
    a_run(x, y, lat);
    n_cmp++;
    if (y !== model_a(x) || lat != B_A) begin
      n_bad++;
      $display("FAIL midscan_empty x=%h: got y=%b lat=%0d want y=%b lat=%0d",
               x, y, lat, model_a(x), B_A);
    end
  endtask

  task automatic test_param();
    logic [2:0] y; int lat; logic [7:0] x;
    x = 8'($urandom);
    b_write(9, 8'h00, 8'h00, 3'b100);
    b_write(12, 8'h00, 8'h00, 3'b011);      // out of range, ignored
    b_write(5, 8'hFF, ~x, 3'b001);          // never matches x
    b_run(x, y, lat);
    n_cmp++;
    if (lat != B_B) begin
      n_bad++; $display("FAIL param_latency: got %0d want %0d", lat, B_B);
    end
    n_cmp++;
    if (y !== model_b(x)) begin
      n_bad++; $display("FAIL param_cube9 x=%h: got %b want %b", x, y, model_b(x));
    end
    b_write(1, 8'hF0, x, 3'b010);           // first beat, matches x
    b_run(x, y, lat);
    n_cmp++;
    if (y !== model_b(x)) begin
      n_bad++; $display("FAIL param_two_cubes x=%h: got %b want %b", x, y, model_b(x));
    end
    b_cfg_clear = 1'b1; b_cfg_we = 1'b1; b_cfg_addr = 4'd0; b_cfg_care = 8'h00;
    b_cfg_omask = 3'b111;                   // clear wins over the write
    @(negedge clk);
    b_cfg_clear = 1'b0; b_cfg_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mb_care[i] = '0; mb_val[i] = '0; mb_om[i] = '0;
    end
    b_run(x, y, lat);
    n_cmp++;
    if (y !== model_b(x)) begin
      n_bad++; $display("FAIL param_clear x=%h: got %b want %b", x, y, model_b(x));
    end
    b_cfg_pol_we = 1'b1; b_cfg_pol = 3'b010;
    @(negedge clk);
    b_cfg_pol_we = 1'b0;
    mb_pol = 3'b010;
    b_run(x, y, lat);
    n_cmp++;
    if (y !== model_b(x)) begin
      n_bad++; $display("FAIL param_empty_pol x=%h: got %b want %b", x, y, model_b(x));
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    a_rst_n = 1'b0; a_cfg_we = 1'b0; a_cfg_pol_we = 1'b0; a_cfg_clear = 1'b0;
    a_cfg_addr = '0; a_cfg_care = '0; a_cfg_val = '0; a_cfg_omask = '0;
    a_cfg_pol = '0; a_in_valid = 1'b0; a_in_x = '0; a_out_ready = 1'b0;
    b_rst_n = 1'b0; b_cfg_we = 1'b0; b_cfg_pol_we = 1'b0; b_cfg_clear = 1'b0;
    b_cfg_addr = '0; b_cfg_care = '0; b_cfg_val = '0; b_cfg_omask = '0;
    b_cfg_pol = '0; b_in_valid = 1'b0; b_in_x = '0; b_out_ready = 1'b0;
    model_a_reset();
    model_b_reset();
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_basic();
    test_last_beat();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    test_param();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
